program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  CPU-side end of the UART boot protocol: announces readiness with 0x99, receives a
//  4-byte little-endian program size, then the program bytes, packs them into 32-bit
//  words written to instruction memory, and answers 0xaa. Sits in top between the
//  UartRx/UartTx instances and imem; asserts done to release the core and the UART.
// PARAMETERS
//  ADDR_WIDTH  15     imem word-address width; capacity = 2**ADDR_WIDTH words
//  BOOT_BYTE   8'h99  byte sent after reset to request the program
//  DONE_BYTE   8'haa  byte sent after the last program byte is stored
// PORTS
//  clock       in   1           system clock, all logic on posedge
//  resetn      in   1           asynchronous, active-low reset
//  rx_ready    in   1           UartRx: one-cycle pulse, rdata valid
//  rdata       in   8           UartRx received byte
//  ferr        in   1           UartRx framing error, qualified by rx_ready
//  tx_busy     in   1           UartTx busy
//  tx_start    out  1           UartTx start, one-cycle pulse
//  sdata       out  8           UartTx byte, valid with tx_start
//  imem_we     out  1           imem write strobe, one cycle per word
//  imem_addr   out  ADDR_WIDTH  imem word address
//  imem_wdata  out  32          imem write word
//  done        out  1           sticky: program loaded and DONE_BYTE issued
//  size_err    out  1           sticky: size exceeded imem capacity
//  ferr_seen   out  1           sticky: a framing-error byte was dropped
// BEHAVIOUR
//  - Reset (async assert): all outputs 0, state S_HELLO, byte/word counters 0.
//  - States: S_HELLO -> S_SIZE -> S_PROG -> S_ACK -> S_DONE (terminal until reset).
//  - Tx rule: tx_start only when tx_busy=0 AND tx_start was 0 in the previous cycle
//    (covers UartTx's one-cycle busy latency); sdata registered with tx_start.
//  - S_HELLO: issue BOOT_BYTE once, go S_SIZE in the same cycle as tx_start.
//  - S_SIZE: 4 accepted bytes, LSB first, form size[31:0]; after 4th byte go S_PROG,
//    or S_ACK directly if size==0.
//  - S_PROG: each accepted byte shifts into word buffer at lane (byte_cnt%4), byte 0
//    -> [7:0]. On 4th lane, or on the final byte (remaining lanes zero-padded):
//    imem_we=1 the cycle after that rx_ready, imem_addr=word index, then index+1.
//    After final byte (count==size) go S_ACK.
//  - Capacity: word index >= 2**ADDR_WIDTH -> no write, size_err=1, bytes still
//    consumed so host stays in sync; index counter saturates, never wraps.
//  - S_ACK: issue DONE_BYTE per tx rule, then S_DONE with done=1 same cycle.
//  - Accepted byte = rx_ready & ~ferr. rx_ready & ferr: byte dropped, ferr_seen=1,
//    counters unchanged. rx_ready in S_HELLO/S_ACK/S_DONE ignored.
//  - Latency: last program byte rx_ready -> imem_we +1 cycle; tx_start no earlier
//    than +2 cycles.
//  - Byte counter 32 bits; size up to 2**32-1 legal (excess words dropped).
//  - resetn mid-load: immediate abort, imem contents left as-is, BOOT_BYTE resent
//    after release.
// STRUCTURE
//  - Shared package: loader_state_t enum, BOOT_BYTE/DONE_BYTE defaults, word width 32.
//  - Sub-module byte_packer: le byte-to-word assembler (load, lane, flush, word out,
//    word_valid); program_loader holds FSM, counters, tx logic.
//  - No UART instances inside; top instantiates UartRx/UartTx and muxes UART to the
//    core when done=1.
// TESTING
//  - Reset release, tx_busy=0 -> one tx_start, sdata=8'h99; no second pulse.
//  - Size 08 00 00 00, bytes 13 00 00 20 01 00 40 00 -> writes addr0=32'h20000013,
//    addr1=32'h00400001; then sdata=8'haa, done=1.
//  - Size 06 00 00 00, bytes aa bb cc dd ee ff -> addr0=ddccbbaa, addr1=0000ffee.
//  - Size 0 -> no imem_we, 8'haa sent right after 4th size byte, done=1.
//  - ADDR_WIDTH=2, size 20 -> 4 writes (addr 0..3), size_err=1, 8'haa after 20 bytes.
//  - ferr on 2nd program byte then good resend -> ferr_seen=1, word correct;
//    resetn pulse mid-S_PROG -> outputs 0, 8'h99 resent.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the UART boot loader: FSM states, handshake bytes, word width.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_HELLO,
        S_SIZE,
        S_PROG,
        S_ACK,
        S_DONE
    } loader_state_t;

    localparam logic [7:0] BOOT_BYTE_DEF = 8'h99;
    localparam logic [7:0] DONE_BYTE_DEF = 8'haa;
    localparam int         WORD_W        = 32;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Little-endian byte-to-word assembler: bytes land at their lane, a full or flushed word
// is presented combinationally and the buffer restarts from zero so short tails are zero-padded.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [1:0]        lane,
    input  logic              flush,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [WORD_W-1:0] buf_q;

    always_comb begin
        word                       = buf_q;
        word[{lane, 3'b000} +: 8]  = byte_in;
        word_valid                 = load & ((lane == 2'd3) | flush);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= word_valid ? '0 : word;
        end
    end

endmodule

// File: rtl/program_loader.sv
// CPU-side UART boot loader: sends BOOT_BYTE, takes a 4-byte LE size and the program,
// writes packed words to imem, answers DONE_BYTE and raises done.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] BOOT_BYTE  = BOOT_BYTE_DEF,
    parameter logic [7:0] DONE_BYTE  = DONE_BYTE_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  rx_ready,
    input  logic [7:0]            rdata,
    input  logic                  ferr,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            sdata,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  done,
    output logic                  size_err,
    output logic                  ferr_seen
);

    loader_state_t     state;
    logic [31:0]       size_q;
    logic [31:0]       byte_cnt;
    logic [ADDR_WIDTH:0] word_idx;

    logic              rx_ok;
    logic              rx_bad;
    logic              rx_phase;
    logic              tx_ok;
    logic              last_byte;
    logic [31:0]       size_next;
    logic              pack_load;
    logic [WORD_W-1:0] pack_word;
    logic              pack_valid;

    assign rx_ok     = rx_ready & ~ferr;
    assign rx_bad    = rx_ready & ferr;
    assign rx_phase  = (state == S_SIZE) || (state == S_PROG);
    // tx_start is itself the "previous cycle" flag, bridging UartTx's busy latency
    assign tx_ok     = ~tx_busy & ~tx_start;
    assign last_byte = (byte_cnt + 32'd1) == size_q;
    assign size_next = {rdata, size_q[31:8]};
    assign pack_load = rx_ok && (state == S_PROG);

    byte_packer u_packer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (pack_load),
        .lane       (byte_cnt[1:0]),
        .flush      (last_byte),
        .byte_in    (rdata),
        .word       (pack_word),
        .word_valid (pack_valid)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_HELLO;
            size_q     <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            tx_start   <= 1'b0;
            sdata      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            size_err   <= 1'b0;
            ferr_seen  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            imem_we  <= 1'b0;
            if (rx_bad && rx_phase) begin
                ferr_seen <= 1'b1;
            end
            case (state)
                S_HELLO: begin
                    if (tx_ok) begin
                        tx_start <= 1'b1;
                        sdata    <= BOOT_BYTE;
                        state    <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (rx_ok) begin
                        size_q <= size_next;
                        if (byte_cnt[1:0] == 2'd3) begin
                            byte_cnt <= '0;
                            state    <= (size_next == 32'd0) ? S_ACK : S_PROG;
                        end else begin
                            byte_cnt <= byte_cnt + 32'd1;
                        end
                    end
                end
                S_PROG: begin
                    if (rx_ok) begin
                        byte_cnt <= byte_cnt + 32'd1;
                        if (pack_valid) begin
                            // Past capacity the index stays saturated; bytes are still consumed
                            if (word_idx[ADDR_WIDTH]) begin
                                size_err <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                                imem_wdata <= pack_word;
                                word_idx   <= word_idx + (ADDR_WIDTH+1)'(1);
                            end
                        end
                        if (last_byte) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (tx_ok) begin
                        tx_start <= 1'b1;
                        sdata    <= DONE_BYTE;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a host model drives the UART side, a monitor
// compares every imem write and tx byte against expectations queued from the protocol rules.
module tb_program_loader;

    localparam int AW  = 2;
    localparam int CAP = 2 ** AW;

    logic            clock = 1'b0;
    logic            resetn;
    logic            rx_ready;
    logic [7:0]      rdata;
    logic            ferr;
    logic            tx_busy;
    logic            tx_start;
    logic [7:0]      sdata;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_wdata;
    logic            done;
    logic            size_err;
    logic            ferr_seen;

    always #5 clock = ~clock;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .ferr       (ferr),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .sdata      (sdata),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .size_err   (size_err),
        .ferr_seen  (ferr_seen)
    );

    typedef struct {
        bit          is_tx;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    byte unsigned     prog[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               last_rx_cyc = 0;
    bit               hold_busy = 1'b0;
    int               busy_cnt = 0;
    bit               exp_ferr;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // UartTx stand-in: busy rises the cycle after tx_start and holds a few cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_start === 1'b1) busy_cnt = 6;
            else if (busy_cnt > 0) busy_cnt--;
            @(posedge clock);
            #1 tx_busy = hold_busy || (busy_cnt > 0);
        end
    end

    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].is_tx) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h required=none", imem_addr, imem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                    check("wr_data", imem_wdata, mon_e.data);
                    check("wr_latency", cyc - last_rx_cyc, 1);
                end
            end
            if (tx_start === 1'b1) begin
                if (exp_q.size() == 0 || !exp_q[0].is_tx) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx sdata=%h required=none", sdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", 32'(sdata), mon_e.data);
                    if (mon_e.data == 32'haa) check("ack_latency_ge2", 32'(cyc - last_rx_cyc >= 2), 1);
                end
            end
        end
    end

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clock);
        #1 resetn = 1'b0;
        hold_busy = (hold > 0);
        rx_ready = 1'b0;
        ferr = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        exp_q.delete();
        check("reset_ctrl", {27'd0, tx_start, imem_we, done, size_err, ferr_seen}, 0);
        check("reset_sdata", {24'd0, sdata}, 0);
        check("reset_addr", 32'(imem_addr), 0);
        check("reset_wdata", imem_wdata, 0);
        exp_q.push_back('{1'b1, '0, 32'h99});
        @(negedge clock);
        resetn = 1'b1;
        if (hold > 0) begin
            repeat (hold) @(posedge clock);
            check("hello_held_while_busy", exp_q.size(), 1);
            hold_busy = 1'b0;
        end
        wait_empty("hello");
        exp_ferr = 1'b0;
    endtask

    task automatic send(input byte unsigned b, input bit f);
        @(posedge clock);
        #1 rx_ready = 1'b1;
        rdata = b;
        ferr = f;
        if (f) exp_ferr = 1'b1;
        else last_rx_cyc = cyc;
        @(posedge clock);
        #1 rx_ready = 1'b0;
        ferr = 1'b0;
        rdata = 8'($urandom);
        repeat ($urandom_range(3, 0)) @(posedge clock);
    endtask

    task automatic maybe_bad(input int pct);
        if (pct > 0 && $urandom_range(99, 0) < pct) send(8'($urandom), 1'b1);
    endtask

    // Host side of one load; stop_at >= 0 abandons the transfer after that many program bytes
    task automatic load(input int unsigned size, input int pct, input int bad_at, input int stop_at);
        int unsigned words;
        logic [31:0] w;
        words = (size + 3) / 4;
        for (int i = 0; i < int'(words); i++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < int'(size)) w = w | (32'(prog[4*i+k]) << (8 * k));
            if (i < CAP) exp_q.push_back('{1'b0, AW'(i), w});
        end
        exp_q.push_back('{1'b1, '0, 32'haa});
        for (int k = 0; k < 4; k++) begin
            maybe_bad(pct);
            send(8'((size >> (8 * k)) & 32'hff), 1'b0);
        end
        for (int i = 0; i < int'(size); i++) begin
            if (i == stop_at) return;
            if (i == bad_at) send(8'($urandom), 1'b1);
            maybe_bad(pct);
            send(prog[i], 1'b0);
        end
        wait_empty("load");
        repeat (15) @(posedge clock);
        check("done", 32'(done), 1);
        check("size_err", 32'(size_err), 32'(words > CAP));
        check("ferr_seen", 32'(ferr_seen), 32'(exp_ferr));
    endtask

    task automatic set_prog(input int unsigned n);
        prog.delete();
        for (int i = 0; i < int'(n); i++) prog.push_back(8'($urandom));
    endtask

    initial begin
        resetn = 1'b1;
        rx_ready = 1'b0;
        rdata = '0;
        ferr = 1'b0;
        exp_ferr = 1'b0;

        do_reset(5);
        repeat (20) @(posedge clock);
        prog = '{8'h13, 8'h00, 8'h00, 8'h20, 8'h01, 8'h00, 8'h40, 8'h00};
        load(8, 0, -1, -1);
        send(8'h55, 1'b0);
        repeat (10) @(posedge clock);

        do_reset(0);
        prog = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
        load(6, 0, -1, -1);

        do_reset(0);
        prog.delete();
        load(0, 0, -1, -1);

        do_reset(0);
        set_prog(20);
        load(20, 0, -1, -1);

        do_reset(0);
        prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(8, 0, 1, -1);

        do_reset(0);
        set_prog(12);
        load(12, 0, -1, 5);
        repeat (2) @(posedge clock);
        do_reset(0);
        set_prog(9);
        load(9, 0, -1, -1);

        for (int t = 0; t < 10; t++) begin
            int unsigned sz;
            sz = $urandom_range(24, 0);
            do_reset(0);
            set_prog(sz);
            load(sz, 15, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
